// File: rtl/bus_slave_sram_pkg.sv
// -----------------------------------------------------------------------------
// bus_slave_sram_pkg
// Shared definitions for the SRAM bus slave: bus word widths, access-direction
// encodings, the slave FSM state encoding and the request-decode helper.
// -----------------------------------------------------------------------------
package bus_slave_sram_pkg;

  localparam int WORD_ADDR_W = 30;  // word address bus width
  localparam int WORD_DATA_W = 32;  // word data bus width
  localparam int WAIT_CNT_W  = 4;   // wait-state counter, covers 0..15

  localparam logic BUS_RD = 1'b1;
  localparam logic BUS_WR = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_e;

  // A request needs both the decoder select and the master strobe (active-low).
  function automatic logic is_req(input logic cs_n, input logic as_n);
    return !cs_n && !as_n;
  endfunction

endpackage

// File: rtl/bus_slave_sram_sram.sv
// -----------------------------------------------------------------------------
// sram_1rw
// Single-port storage, synchronous write, asynchronous read. Kept as its own
// module so it can be replaced by a vendor macro. The read path is
// combinational so a zero-wait-state read can complete in the READY cycle.
// Contents have no reset.
//   clk      : clock
//   we_i     : write enable, write happens at the rising edge
//   addr_i   : word address
//   wdata_i  : write data
//   rdata_o  : read data for addr_i (combinational)
// -----------------------------------------------------------------------------
module sram_1rw #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/bus_slave_sram.sv
// -----------------------------------------------------------------------------
// bus_slave_sram
// Bus slave fronting a 2^ADDR_W x 32 SRAM. A request (cs_ = 0 and as_ = 0) is
// taken in IDLE only; address, direction and write data are latched, then
// WAIT_CYCLES wait states run before a one-cycle READY strobe (rdy_ = 0).
// Reads drive rdData during READY; writes commit at the edge ending READY.
// rdData is 0 whenever rdy_ = 1 so the output can be OR-ed onto a shared bus.
//   clk     : clock
//   reset   : synchronous, active-high
//   cs_     : chip select, active-low
//   as_     : address strobe, active-low
//   rw      : 1 = read, 0 = write
//   addr    : word address, only [ADDR_W-1:0] decoded (upper bits alias)
//   wrData  : write data
//   rdData  : read data, valid in READY of a read, else 0
//   rdy_    : access complete, active-low, one cycle
// -----------------------------------------------------------------------------
module bus_slave_sram
  import bus_slave_sram_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2   // 0..15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cs_,
  input  logic                   as_,
  input  logic                   rw,
  input  logic [WORD_ADDR_W-1:0] addr,
  input  logic [WORD_DATA_W-1:0] wrData,
  output logic [WORD_DATA_W-1:0] rdData,
  output logic                   rdy_
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LD = WAIT_CNT_W'(WAIT_CYCLES);

  state_e                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    rw_q, rw_d;
  logic [WORD_DATA_W-1:0]  wdata_q, wdata_d;

  logic                    ready;
  logic                    mem_we;
  logic [WORD_DATA_W-1:0]  mem_rdata;

  // Upper address bits are deliberately ignored (aliasing).
  generate
    if (ADDR_W < WORD_ADDR_W) begin : g_alias
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr[WORD_ADDR_W-1:ADDR_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= BUS_RD;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (is_req(cs_, as_)) begin
          addr_d  = addr[ADDR_W-1:0];
          rw_d    = rw;
          wdata_d = wrData;
          cnt_d   = WAIT_LD;
          state_d = (WAIT_CYCLES == 0) ? ST_READY : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        // Leave on the edge where the count hits zero; <= also covers a
        // corrupted zero count so WAIT can never lock up.
        if (cnt_q <= WAIT_CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_READY;
        end
      end
      ST_READY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign ready  = (state_q == ST_READY);
  assign rdy_   = !ready;
  // A reset landing on the READY edge aborts the access, write included.
  assign mem_we = ready && (rw_q == BUS_WR) && !reset;
  assign rdData = (ready && (rw_q == BUS_RD)) ? mem_rdata : '0;

  sram_1rw #(
    .ADDR_W (ADDR_W),
    .DATA_W (WORD_DATA_W)
  ) u_sram (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

endmodule

// File: tb/tb_bus_slave_sram.sv
// -----------------------------------------------------------------------------
// tb_bus_slave_sram
// Two slaves (WAIT_CYCLES = 2 and 0) share one stimulus stream. A transaction
// level model predicts, per slave, which cycle carries the ready strobe and
// what rdData must be; every stimulus cycle is compared. Literal expectations
// pin the directed scenarios.
// Slave index 0 = WAIT_CYCLES 2, index 1 = WAIT_CYCLES 0.
// -----------------------------------------------------------------------------
module tb_bus_slave_sram;

  logic              clk = 1'b0;
  logic              reset;
  logic              cs_, as_, rw;
  logic [29:0]       addr;
  logic [31:0]       wrData;
  logic [1:0]        rdy_n;
  logic [1:0][31:0]  rdd;

  always #5 clk = ~clk;

  bus_slave_sram #(.ADDR_W(10), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .reset(reset), .cs_(cs_), .as_(as_), .rw(rw), .addr(addr),
    .wrData(wrData), .rdData(rdd[0]), .rdy_(rdy_n[0]));

  bus_slave_sram #(.ADDR_W(10), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .cs_(cs_), .as_(as_), .rw(rw), .addr(addr),
    .wrData(wrData), .rdData(rdd[1]), .rdy_(rdy_n[1]));

  function automatic int wc(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  // ---------------- transaction model ----------------
  int          cyc = 0;
  bit          pend [2];
  int          due  [2];
  logic [9:0]  ma   [2];
  bit          mrw  [2];
  logic [31:0] mwd  [2];
  logic [31:0] mm   [2][1024];
  bit          known[2][1024];

  // Each access: accepted at the end of cycle c (slave free), completes in
  // cycle c+1+W, write lands at the end of that cycle unless reset is seen.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        pend[d] <= 1'b0;
      end else if (pend[d] && due[d] == cyc) begin
        if (!mrw[d]) begin
          mm[d][ma[d]]    <= mwd[d];
          known[d][ma[d]] <= 1'b1;
        end
        pend[d] <= 1'b0;
      end else if (!pend[d] && !cs_ && !as_) begin
        pend[d] <= 1'b1;
        due[d]  <= cyc + 1 + wc(d);
        ma[d]   <= addr[9:0];
        mrw[d]  <= rw;
        mwd[d]  <= wrData;
      end
    end
    cyc <= cyc + 1;
  end

  // ---------------- checking ----------------
  int          checks = 0;
  int          errors = 0;
  int          since;
  int          obs_lat [2];
  logic [31:0] obs_dat [2];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    bit act;
    @(negedge clk);
    since++;
    for (int d = 0; d < 2; d++) begin
      act = pend[d] && (due[d] == cyc);
      check($sformatf("rdy_ s%0d", d), {31'd0, rdy_n[d]}, {31'd0, !act});
      if (act && mrw[d]) begin
        if (known[d][ma[d]]) check($sformatf("rdData s%0d", d), rdd[d], mm[d][ma[d]]);
      end else begin
        check($sformatf("rdData_zero s%0d", d), rdd[d], 32'd0);
      end
      if (!rdy_n[d] && obs_lat[d] == 0) begin
        obs_lat[d] = since;
        obs_dat[d] = rdd[d];
      end
    end
  endtask

  task automatic clear_obs();
    since = 0;
    obs_lat[0] = 0;
    obs_lat[1] = 0;
    obs_dat[0] = '0;
    obs_dat[1] = '0;
  endtask

  // Bus noise while the slave is busy; never forms a request.
  task automatic junk();
    cs_    = 1'($urandom);
    as_    = 1'b1;
    rw     = 1'($urandom);
    addr   = 30'($urandom);
    wrData = $urandom;
  endtask

  // One-cycle request; optional reset pulse in the first cycle after accept.
  task automatic txn(input bit r, input logic [29:0] a, input logic [31:0] wd,
                     input int gap, input bit abort);
    cs_ = 1'b0; as_ = 1'b0; rw = r; addr = a; wrData = wd;
    clear_obs();
    tick();
    junk();
    reset = abort;
    for (int k = 0; k < gap; k++) begin
      tick();
      reset = 1'b0;
      junk();
    end
  endtask

  localparam bit RD = 1'b1;
  localparam bit WR = 1'b0;

  initial begin
    reset = 1'b1; cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; addr = '0; wrData = '0;
    clear_obs();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Idle after reset
    repeat (5) tick();
    check("idle_rdy", {30'd0, rdy_n}, 32'd3);
    check("idle_data_s0", rdd[0], 32'd0);

    // Write then read, latency pinned
    txn(WR, 30'h005, 32'hDEADBEEF, 3, 1'b0);
    check("wr_lat_s0", obs_lat[0], 3);
    check("wr_lat_s1", obs_lat[1], 1);
    txn(RD, 30'h005, 32'h0, 3, 1'b0);
    check("rd_lat_s0", obs_lat[0], 3);
    check("rd_lat_s1", obs_lat[1], 1);
    check("rd_dat_s0", obs_dat[0], 32'hDEADBEEF);
    check("rd_dat_s1", obs_dat[1], 32'hDEADBEEF);

    // Inputs scrambled during wait must not matter (junk() does the scrambling)
    txn(WR, 30'h007, 32'hCAFEF00D, 3, 1'b0);
    txn(RD, 30'h007, 32'h0, 3, 1'b0);
    check("latched_s0", obs_dat[0], 32'hCAFEF00D);
    check("latched_s1", obs_dat[1], 32'hCAFEF00D);

    // Back-to-back reads on the zero-wait slave
    txn(WR, 30'h000, 32'h11111111, 3, 1'b0);
    txn(WR, 30'h3FF, 32'h22222222, 3, 1'b0);
    txn(RD, 30'h000, 32'h0, 1, 1'b0);
    check("b2b1_lat_s1", obs_lat[1], 1);
    check("b2b1_dat_s1", obs_dat[1], 32'h11111111);
    txn(RD, 30'h3FF, 32'h0, 3, 1'b0);
    check("b2b2_lat_s1", obs_lat[1], 1);
    check("b2b2_dat_s1", obs_dat[1], 32'h22222222);
    check("b2b_busy_s0", obs_dat[0], 32'h11111111);
    txn(RD, 30'h3FF, 32'h0, 3, 1'b0);
    check("rd3ff_s0", obs_dat[0], 32'h22222222);

    // Reset during the wait of a write aborts it
    txn(WR, 30'h010, 32'h12345678, 3, 1'b0);
    txn(WR, 30'h010, 32'hAAAA5555, 5, 1'b1);
    check("abort_no_rdy_s0", obs_lat[0], 0);
    txn(RD, 30'h010, 32'h0, 3, 1'b0);
    check("abort_keep_s0", obs_dat[0], 32'h12345678);
    check("abort_keep_s1", obs_dat[1], 32'h12345678);

    // Strobe coincident with reset is ignored
    reset = 1'b1; cs_ = 1'b0; as_ = 1'b0; rw = 1'b1;
    clear_obs();
    tick();
    reset = 1'b0; cs_ = 1'b1; as_ = 1'b1;
    repeat (4) tick();
    check("rst_as_s0", obs_lat[0], 0);
    check("rst_as_s1", obs_lat[1], 0);

    // Upper address bits alias
    txn(RD, 30'h0000405, 32'h0, 3, 1'b0);
    check("alias_s0", obs_dat[0], 32'hDEADBEEF);
    check("alias_s1", obs_dat[1], 32'hDEADBEEF);

    // Strobe without chip select is not a request
    cs_ = 1'b1; as_ = 1'b0;
    clear_obs();
    repeat (20) tick();
    check("nocs_s0", obs_lat[0], 0);
    check("nocs_s1", obs_lat[1], 0);
    as_ = 1'b1;
    tick();

    // Randomized traffic over 32 addresses with aliased upper bits
    for (int i = 0; i < 32; i++)
      txn(WR, {20'($urandom), (i < 16) ? 10'(i) : 10'(992 + i)}, $urandom, 3, 1'b0);
    for (int n = 0; n < 120; n++) begin
      int  i;
      int  g;
      bit  ab;
      i  = $urandom_range(0, 31);
      g  = (($urandom_range(0, 3)) == 0) ? 1 : $urandom_range(3, 4);
      ab = ($urandom_range(0, 9) == 0);
      txn(1'($urandom), {20'($urandom), (i < 16) ? 10'(i) : 10'(992 + i)},
          $urandom, ab ? 4 : g, ab);
    end
    cs_ = 1'b1; as_ = 1'b1;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
